// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the register-file slice.
//   DATA_W_DEF / N_REGS_DEF / N_RD_DEF : default widths and port count
//   N_RD_MAX                           : largest supported number of read ports
//   clog2()                            : elaboration-time ceiling log2
//   rd_src_e                           : where a read port takes its data from
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_REGS_DEF = 32;
  localparam int N_RD_DEF   = 2;
  localparam int N_RD_MAX   = 4;

  // Ceiling log2, used to size register addresses from the register count.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Data source selected by each read port.
  typedef enum logic [1:0] {
    RD_SRC_ZERO   = 2'd0,  // register 0: hard-wired zero
    RD_SRC_BYPASS = 2'd1,  // same-cycle writeback forwarded
    RD_SRC_ARRAY  = 2'd2   // stored register value
  } rd_src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- one pending bit per register plus a population counter.
//   clk, rst          : clock, asynchronous active-high reset
//   res_en, res_addr  : reserve (mark pending) a destination register
//   wr_en, wr_addr    : writeback, clears the pending bit of wr_addr
//   pend              : pending bit vector, bit 0 is always 0
//   pend_cnt          : registered count of pending bits (never wraps)
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter  int N_REGS = N_REGS_DEF,
  localparam int ADDR_W = clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [N_REGS-1:0] pend,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [N_REGS-1:0] pend_q;
  logic [N_REGS-1:0] pend_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              res_live;
  logic              wr_live;
  logic              inc;
  logic              dec;

  // Register 0 can never become pending.
  assign pend_d[0] = 1'b0;

  // A reservation takes priority over a writeback to the same register,
  // so the most recently issued producer keeps ownership.
  genvar gi;
  generate
    for (gi = 1; gi < N_REGS; gi++) begin : g_pend
      assign pend_d[gi] = (res_en && (res_addr == ADDR_W'(gi))) ||
                          (pend_q[gi] && !(wr_en && (wr_addr == ADDR_W'(gi))));
    end
  endgenerate

  // The counter tracks only real transitions of the bit vector: a set of an
  // already-pending bit, or a clear of an idle bit, leaves it unchanged.
  always_comb begin
    res_live = res_en && (res_addr != '0);
    wr_live  = wr_en && (wr_addr != '0);
    inc      = res_live && !pend_q[res_addr];
    dec      = wr_live && pend_q[wr_addr] &&
               !(res_live && (res_addr == wr_addr));
    cnt_d    = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/banco_reg_sb.sv
// banco_reg_sb -- register file with writeback bypass and a pending scoreboard.
//   clk, rst              : clock, asynchronous active-high reset
//   rd_addr  [N_RD*ADDR_W]: read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [N_RD*DATA_W]: combinational read data, port k at [k*DATA_W +: DATA_W]
//   rd_ready [N_RD]       : 1 when rd_data of that port is not awaiting a writeback
//   wr_en/wr_addr/wr_data : writeback port (register 0 ignores writes)
//   res_en/res_addr       : reserve a destination register at issue
//   pend_cnt              : number of pending registers
//   busy                  : any register pending
// N_RD must lie in 1..N_RD_MAX and N_REGS must be a power of two >= 4.
module banco_reg_sb
  import mips_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int N_REGS = N_REGS_DEF,
  parameter  int N_RD   = N_RD_DEF,
  localparam int ADDR_W = clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_ready,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   res_en,
  input  logic [ADDR_W-1:0]      res_addr,
  output logic [ADDR_W:0]        pend_cnt,
  output logic                   busy
);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [N_REGS-1:0] pend;

  reg_scoreboard #(
    .N_REGS (N_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .res_en   (res_en),
    .res_addr (res_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .pend     (pend),
    .pend_cnt (pend_cnt)
  );

  assign busy = (pend_cnt != '0);

  // Storage. Writes to register 0 are dropped so that entry stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // The array is reset asynchronously, so it is built from flops rather
  // than block RAM; reads must also be combinational.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports. The bypass path is independent of rst, so a writeback
  // presented during reset is still visible on a matching read port even
  // though the write itself is discarded.
  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      rd_src_e           src;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        if (addr == '0) begin
          src = RD_SRC_ZERO;
        end else if (wr_en && (wr_addr == addr)) begin
          src = RD_SRC_BYPASS;
        end else begin
          src = RD_SRC_ARRAY;
        end
      end

      always_comb begin
        case (src)
          RD_SRC_ZERO:   data = '0;
          RD_SRC_BYPASS: data = wr_data;
          default:       data = regs_q[addr];
        endcase
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      // Forwarded data is always valid; register 0 is never pending.
      assign rd_ready[gi] = (src != RD_SRC_ARRAY) || !pend[addr];
    end
  endgenerate

endmodule

// File: tb/tb_banco_reg_sb.sv
// tb_banco_reg_sb -- directed bench for banco_reg_sb with a behavioural model
// (register array + pending set) checked every cycle, plus literal checks.
module tb_banco_reg_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]  rd_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            res_en;
  logic [AW-1:0]   res_addr;
  logic [AW:0]     pend_cnt;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int pop;

  // Behavioural model: register contents and the set of pending registers.
  logic [DW-1:0] m_reg  [NR];
  bit            m_pend [NR];

  always #5 clk = ~clk;

  banco_reg_sb #(
    .DATA_W (DW),
    .N_REGS (NR),
    .N_RD   (NRD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .res_en   (res_en),
    .res_addr (res_addr),
    .pend_cnt (pend_cnt),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Model update: a writeback stores data and releases the register, then a
  // reservation (applied last, so it wins) marks its register pending.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  <= wr_data;
        m_pend[wr_addr] <= 1'b0;
      end
      if (res_en && res_addr != 0) begin
        m_pend[res_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_ready(input logic [AW-1:0] a);
    if (a == 0) return 1'b1;
    if (wr_en && wr_addr == a) return 1'b1;
    return !m_pend[a];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      pop = 0;
      for (int i = 0; i < NR; i++) pop += int'(m_pend[i]);
      for (int k = 0; k < NRD; k++) begin
        check("cyc_rd_data", 64'(rd_data[k*DW +: DW]), 64'(exp_data(rd_addr[k*AW +: AW])));
        check("cyc_rd_ready", 64'(rd_ready[k]), 64'(exp_ready(rd_addr[k*AW +: AW])));
      end
      check("cyc_pend_cnt", 64'(pend_cnt), 64'(pop));
      check("cyc_busy", 64'(busy), 64'(pop != 0));
    end
  end

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(posedge clk);
    #1;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    res_en   = re;
    res_addr = ra;
    rd_addr  = {a1, a0};
    $display("txn t=%0t wr=%0b a=%0d d=%h res=%0b a=%0d rd0=%0d rd1=%0d",
             $time, we, wa, wd, re, ra, a0, a1);
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(1'b0, '0, '0, 1'b0, '0, a0, a1);
  endtask

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0;
    res_en = 0; res_addr = 0; rd_addr = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    // Outputs held at their reset values.
    check("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_ready", 64'(rd_ready), 64'b11);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    // Bypass still forwards during reset, but the write is lost.
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h0000_0077; rd_addr = {5'd0, 5'd3};
    #1;
    check("rst_bypass_data", 64'(rd_data[DW-1:0]), 64'h77);
    check("rst_bypass_ready", 64'(rd_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = {5'd0, 5'd3};
    chk_en = 1'b1;
    #1;
    check("rst_write_lost", 64'(rd_data[DW-1:0]), 64'd0);

    // Write r5, read it back next cycle.
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    idle(5'd5, 5'd0);
    #1;
    check("r5_data", 64'(rd_data[DW-1:0]), 64'hDEAD_BEEF);
    check("r5_ready", 64'(rd_ready[0]), 64'd1);

    // Register 0 ignores writes and reservations.
    drive(1, 5'd0, 32'h1234_5678, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5'd0, 0, 0);
    #1;
    check("r0_data", 64'(rd_data[DW-1:0]), 64'd0);
    idle(5'd0, 5'd0);
    #1;
    check("r0_pend_cnt", 64'(pend_cnt), 64'd0);

    // Reserve r7, then write it back with port 1 reading it.
    drive(0, 0, 0, 1, 5'd7, 0, 0);
    idle(5'd7, 5'd0);
    #1;
    check("r7_pend_cnt", 64'(pend_cnt), 64'd1);
    check("r7_busy", 64'(busy), 64'd1);
    check("r7_not_ready", 64'(rd_ready[0]), 64'd0);
    drive(1, 5'd7, 32'hCAFE_0001, 0, 0, 5'd0, 5'd7);
    #1;
    check("r7_bypass_data", 64'(rd_data[2*DW-1:DW]), 64'hCAFE_0001);
    check("r7_bypass_ready", 64'(rd_ready[1]), 64'd1);
    idle(5'd0, 5'd7);
    #1;
    check("r7_released_cnt", 64'(pend_cnt), 64'd0);
    check("r7_released_busy", 64'(busy), 64'd0);

    // Reserve and write r9 in the same cycle: new producer keeps it pending.
    drive(0, 0, 0, 1, 5'd9, 0, 0);
    drive(1, 5'd9, 32'h0000_0055, 1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    #1;
    check("r9_data", 64'(rd_data[DW-1:0]), 64'h55);
    check("r9_still_pending", 64'(rd_ready[0]), 64'd0);
    check("r9_pend_cnt", 64'(pend_cnt), 64'd1);
    drive(1, 5'd9, 32'h0000_0066, 0, 0, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    #1;
    check("r9_cleared_cnt", 64'(pend_cnt), 64'd0);

    // Set and clear of different registers in one cycle; re-reserve; write idle reg.
    drive(0, 0, 0, 1, 5'd10, 0, 0);
    drive(1, 5'd10, 32'h1, 1, 5'd11, 5'd10, 5'd11);
    idle(5'd10, 5'd11);
    #1;
    check("swap_pend_cnt", 64'(pend_cnt), 64'd1);
    drive(0, 0, 0, 1, 5'd11, 5'd11, 5'd0);
    idle(5'd11, 5'd0);
    #1;
    check("rereserve_cnt", 64'(pend_cnt), 64'd1);
    drive(1, 5'd12, 32'h0000_00AB, 0, 0, 5'd12, 5'd11);
    idle(5'd12, 5'd11);
    #1;
    check("idle_write_data", 64'(rd_data[DW-1:0]), 64'hAB);
    check("idle_write_cnt", 64'(pend_cnt), 64'd1);
    drive(1, 5'd11, 32'h0000_0011, 0, 0, 5'd11, 5'd12);

    // Fill every register with a pattern, reading the target and its neighbour.
    for (int i = 1; i < NR; i++) begin
      drive(1, AW'(i), (DW'(i) * 32'h0101_0101) ^ 32'hA5A5_0000, 0, 0, AW'(i), AW'(i - 1));
    end
    // Reserve every register: counter reaches its maximum.
    for (int i = 1; i < NR; i++) begin
      drive(0, 0, 0, 1, AW'(i), AW'(i), AW'(NR - i));
    end
    idle(5'd1, 5'd31);
    #1;
    check("full_pend_cnt", 64'(pend_cnt), 64'd31);
    check("full_busy", 64'(busy), 64'd1);
    // Release every register in reverse order.
    for (int i = NR - 1; i >= 1; i--) begin
      drive(1, AW'(i), DW'(i) + 32'h0000_1000, 0, 0, AW'(i), AW'(i + 1));
    end
    idle(5'd4, 5'd30);
    #1;
    check("empty_pend_cnt", 64'(pend_cnt), 64'd0);
    check("r4_reload", 64'(rd_data[DW-1:0]), 64'h0000_1004);

    // Reset in the middle of a cycle with reservations outstanding.
    drive(0, 0, 0, 1, 5'd1, 5'd5, 5'd9);
    drive(0, 0, 0, 1, 5'd2, 5'd5, 5'd9);
    drive(0, 0, 0, 1, 5'd3, 5'd5, 5'd9);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pend_cnt", 64'(pend_cnt), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rd_data", 64'(rd_data), 64'd0);
    check("midrst_rd_ready", 64'(rd_ready), 64'b11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 0; res_en = 0; rd_addr = {5'd9, 5'd5};
    #1;
    check("postrst_rd_data", 64'(rd_data), 64'd0);
    check("postrst_rd_ready", 64'(rd_ready), 64'b11);
    idle(5'd1, 5'd3);
    idle(5'd2, 5'd0);
    @(posedge clk);
    #6;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/banco_reg_sb.md
BANCO_REG_SB -- requirements
Module: banco_reg_sb

Interface
REQ-001 Parameter DATA_W, default 32: width of each register in bits.
REQ-002 Parameter N_REGS, default 32: number of registers; power of two, at least 4; ADDR_W = clog2(N_REGS).
REQ-003 Parameter N_RD, default 2: number of read ports, 1 to 4.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port rd_addr, input, N_RD*ADDR_W: read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-007 Port rd_data, output, N_RD*DATA_W: read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-008 Port rd_ready, output, N_RD: per-port flag, 1 = rd_data[k] is valid, not awaiting a writeback.
REQ-009 Port wr_en, input, 1: writeback enable.
REQ-010 Port wr_addr, input, ADDR_W: writeback destination.
REQ-011 Port wr_data, input, DATA_W: writeback data.
REQ-012 Port res_en, input, 1: reserve destination (instruction issue marks register pending).
REQ-013 Port res_addr, input, ADDR_W: register to reserve.
REQ-014 Port pend_cnt, output, ADDR_W+1: number of currently pending registers.
REQ-015 Port busy, output, 1: high when pend_cnt != 0.

Function
REQ-016 Register 0 SHALL read as zero, ignore writes, never become pending; rd_ready for address 0 SHALL always be 1.
REQ-017 Reads SHALL be combinational: zero cycles of latency from rd_addr to rd_data.
REQ-018 A write with wr_en=1 and wr_addr!=0 SHALL update the register on the rising edge.
REQ-019 Bypass: when wr_en=1 and wr_addr==rd_addr[k]!=0, rd_data[k] SHALL equal wr_data in the same cycle.
REQ-020 Bypass: under the condition of REQ-019, rd_ready[k] SHALL be 1 in the same cycle.
REQ-021 Otherwise rd_ready[k] SHALL be the inverse of the pending bit of rd_addr[k].
REQ-022 Each register SHALL have one pending bit.
REQ-023 The pending bit SHALL set at the edge when res_en=1 and res_addr matches, excluding register 0.
REQ-024 The pending bit SHALL clear at the edge when wr_en=1 and wr_addr matches.
REQ-025 Simultaneous reserve and write to the same register: data SHALL be written and the pending bit SHALL remain/become 1, so the new producer wins.
REQ-026 Reserving an already-pending register SHALL leave it pending and pend_cnt unchanged.
REQ-027 A write to a non-pending register SHALL be legal: data written, pend_cnt unchanged.
REQ-028 pend_cnt SHALL be a registered counter: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both occur to different registers in one cycle.
REQ-029 pend_cnt SHALL equal the population count of the pending bits at every edge.
REQ-030 pend_cnt SHALL never wrap; its maximum is N_REGS-1.
REQ-031 busy SHALL be derived combinationally from pend_cnt.

Reset
REQ-032 While rst=1, all registers SHALL be 0.
REQ-033 While rst=1, all pending bits SHALL be 0.
REQ-034 While rst=1, pend_cnt SHALL be 0 and busy SHALL be 0.
REQ-035 During reset, rd_ready SHALL be all ones and rd_data SHALL be all zeros, except when a bypass per REQ-019 is active.
REQ-036 Reset asserted mid-operation SHALL discard pending reservations immediately, without waiting for a clock edge.
REQ-037 Writes presented during reset SHALL be lost.

Structure
REQ-038 The default widths, the N_RD limit and a clog2 function SHALL live in the shared package mips_pkg.
REQ-039 The pending-bit array and the pending counter SHALL form one sub-module, reg_scoreboard.
REQ-040 The storage array, bypass muxes and read ports SHALL remain in banco_reg_sb.

Verification
REQ-041 Reset, then write 0xDEADBEEF to r5; next cycle read r5 on port 0 -> 0xDEADBEEF, rd_ready[0]=1.
REQ-042 Write 0x12345678 to r0, then read r0 -> 0x00000000; res_en on r0 -> pend_cnt stays 0.
REQ-043 Reserve r7 -> pend_cnt=1, busy=1, rd_ready=0 for r7.
REQ-044 Continuing REQ-043: write 0xCAFE0001 to r7 with port 1 reading r7 -> same cycle rd_data[1]=0xCAFE0001, rd_ready[1]=1; next cycle pend_cnt=0, busy=0.
REQ-045 r9 pending; same cycle res r9 and wr r9=0x55 -> r9 holds 0x55, still pending, pend_cnt=1.
REQ-046 Reserve r1, r2, r3 on consecutive cycles, assert rst between edges -> pend_cnt=0 and all registers 0 immediately; after reset deassertion reads return 0, ready=1.
